// File: rtl/coin_acceptor_if.sv
// Coin-side and machine-side signals of coin_acceptor; slave is the acceptor, master the coin mech/bench.
// total_in/total_refund exist only when COIN_ACCEPTOR_AUDIT_EN is defined.
interface coin_acceptor_if #(
    parameter int VAL_W = 3
);
    logic             coin_valid;
    logic [VAL_W-1:0] coin_value;
    logic             coin_ready;
    logic             cancel_req;
    logic             vend_done;
    logic             vm_coin;
    logic             vm_cancel;
    logic             refund_pulse;
    logic             coin_reject;
    logic [3:0]       credit;
    logic             busy;
`ifdef COIN_ACCEPTOR_AUDIT_EN
    logic [15:0]      total_in;
    logic [15:0]      total_refund;

    modport slave (
        input  coin_valid, coin_value, cancel_req, vend_done,
        output coin_ready, vm_coin, vm_cancel, refund_pulse, coin_reject, credit, busy,
        output total_in, total_refund
    );
    modport master (
        output coin_valid, coin_value, cancel_req, vend_done,
        input  coin_ready, vm_coin, vm_cancel, refund_pulse, coin_reject, credit, busy,
        input  total_in, total_refund
    );
`else
    modport slave (
        input  coin_valid, coin_value, cancel_req, vend_done,
        output coin_ready, vm_coin, vm_cancel, refund_pulse, coin_reject, credit, busy
    );
    modport master (
        output coin_valid, coin_value, cancel_req, vend_done,
        input  coin_ready, vm_coin, vm_cancel, refund_pulse, coin_reject, credit, busy
    );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: serialises multi-unit coins into vm_coin pulses, tracks machine credit, refunds on cancel.
// Optional audit counters (total_in/total_refund) enabled by COIN_ACCEPTOR_AUDIT_EN.
module coin_acceptor #(
    parameter int VAL_W      = 3,
    parameter int MAX_CREDIT = 5,
    parameter int GAP        = 1
) (
    input  logic            clk,
    input  logic            rst,     // active-low, asynchronous
    coin_acceptor_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_EMIT_HI, S_EMIT_GAP, S_CANCEL, S_REFUND_HI, S_REFUND_GAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [VAL_W-1:0] r_pending;
    logic [3:0]       r_credit;
    logic [3:0]       r_gap_cnt;
    logic             r_cancel_prev;
    logic             r_cancel_sticky;
    logic             r_ready_en;
    logic             r_coin_reject;

    logic             w_cancel_rise;
    logic             w_coin_ready;
    logic             w_fire;
    logic             w_fits;
    logic             w_gap_done;
    logic             w_stop;
    logic             w_pending_left;
    logic [3:0]       w_credit_base;
    logic [4:0]       w_credit_sum;
    logic             w_vm_coin;
    logic             w_vm_cancel;
    logic             w_refund_pulse;
    logic             w_busy;

    assign w_cancel_rise  = bus.cancel_req & ~r_cancel_prev;
    assign w_coin_ready   = r_ready_en & (r_state == S_IDLE) & ~bus.cancel_req;
    assign w_fire         = bus.coin_valid & w_coin_ready;
    // A coin arriving alongside vend_done is judged against the already-cleared credit
    assign w_credit_base  = bus.vend_done ? 4'd0 : r_credit;
    assign w_credit_sum   = {1'b0, w_credit_base} + 5'(bus.coin_value);
    assign w_fits         = (bus.coin_value != '0) && (w_credit_sum <= 5'(MAX_CREDIT));
    assign w_gap_done     = (r_gap_cnt == 4'd0);
    assign w_stop         = r_cancel_sticky | w_cancel_rise;
    assign w_pending_left = ~bus.vend_done & (r_pending != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_cancel_rise)         w_next = S_CANCEL;
                else if (w_fire && w_fits) w_next = S_EMIT_HI;
            end
            S_EMIT_HI:  w_next = S_EMIT_GAP;
            S_EMIT_GAP: begin
                if (w_gap_done) begin
                    if (w_stop)              w_next = S_CANCEL;
                    else if (w_pending_left) w_next = S_EMIT_HI;
                    else                     w_next = S_IDLE;
                end
            end
            S_CANCEL:     w_next = (r_credit != 4'd0) ? S_REFUND_HI : S_IDLE;
            S_REFUND_HI:  w_next = S_REFUND_GAP;
            S_REFUND_GAP: begin
                if (w_gap_done) w_next = (r_credit != 4'd0) ? S_REFUND_HI : S_IDLE;
            end
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_vm_coin      = 1'b0;
        w_vm_cancel    = 1'b0;
        w_refund_pulse = 1'b0;
        w_busy         = (r_state != S_IDLE);
        unique case (r_state)
            S_EMIT_HI:   w_vm_coin      = 1'b1;
            S_CANCEL:    w_vm_cancel    = 1'b1;
            S_REFUND_HI: w_refund_pulse = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending       <= '0;
            r_credit        <= 4'd0;
            r_gap_cnt       <= 4'd0;
            r_cancel_prev   <= 1'b0;
            r_cancel_sticky <= 1'b0;
            r_ready_en      <= 1'b0;
            r_coin_reject   <= 1'b0;
        end else begin
            r_cancel_prev <= bus.cancel_req;
            r_ready_en    <= 1'b1;
            r_coin_reject <= w_fire & ~w_fits;
            unique case (r_state)
                S_IDLE: begin
                    r_credit <= w_credit_base;
                    if (w_fire && w_fits) r_pending <= bus.coin_value;
                end
                S_EMIT_HI: begin
                    r_gap_cnt <= 4'(GAP - 1);
                    if (w_cancel_rise) r_cancel_sticky <= 1'b1;
                    if (bus.vend_done) begin
                        r_credit  <= 4'd0;
                        r_pending <= '0;
                    end else begin
                        r_credit  <= r_credit + 4'd1;
                        r_pending <= r_pending - 1'b1;
                    end
                end
                S_EMIT_GAP: begin
                    if (!w_gap_done) r_gap_cnt <= r_gap_cnt - 4'd1;
                    if (w_cancel_rise) r_cancel_sticky <= 1'b1;
                    // On a cancel, undelivered units become credit so the refund returns the whole coin
                    if (bus.vend_done) begin
                        r_credit  <= 4'd0;
                        r_pending <= '0;
                    end else if (w_gap_done && w_stop) begin
                        r_credit  <= r_credit + 4'(r_pending);
                        r_pending <= '0;
                    end
                    if (w_gap_done && w_stop) r_cancel_sticky <= 1'b0;
                end
                S_REFUND_HI: begin
                    r_gap_cnt <= 4'(GAP - 1);
                    r_credit  <= r_credit - 4'd1;
                end
                S_REFUND_GAP: begin
                    if (!w_gap_done) r_gap_cnt <= r_gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef COIN_ACCEPTOR_AUDIT_EN
    logic [15:0] r_total_in;
    logic [15:0] r_total_refund;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total_in     <= 16'd0;
            r_total_refund <= 16'd0;
        end else begin
            if (w_vm_coin && r_total_in != 16'hFFFF)          r_total_in     <= r_total_in + 16'd1;
            if (w_refund_pulse && r_total_refund != 16'hFFFF) r_total_refund <= r_total_refund + 16'd1;
        end
    end

    assign bus.total_in     = r_total_in;
    assign bus.total_refund = r_total_refund;
`endif

    assign bus.coin_ready   = w_coin_ready;
    assign bus.vm_coin      = w_vm_coin;
    assign bus.vm_cancel    = w_vm_cancel;
    assign bus.refund_pulse = w_refund_pulse;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.credit       = r_credit;
    assign bus.busy         = w_busy;
endmodule
